div_ctrl: RTL



---
 rtl/div_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one divide/remainder request at a time between the
// EX-stage M-extension issue logic and the iterative divider.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake; req_op (funct3), req_dividend, req_divisor
//   flush              kills the in-flight operation
//   resp_valid/ready   response handshake; resp_data, resp_err (watchdog result)
//   busy               controller not idle
//   div_start          one-cycle start pulse to the divider
//   div_op/dividend/divisor  latched operands, held stable for the divider
//   div_fin            divider done pulse; div_quotient/div_remainder valid with it
module div_ctrl #(
    parameter int TIMEOUT  = 64,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic        div_start,
    output logic [2:0]  div_op,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_fin,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   dvd_q, dvd_d;
    logic [31:0]   dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          orphan_q, orphan_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;
    logic          c_valid_q, c_valid_d;
    logic [31:0]   c_dvd_q, c_dvd_d;
    logic [31:0]   c_dvs_q, c_dvs_d;
    logic          c_uns_q, c_uns_d;
    logic [31:0]   c_quo_q, c_quo_d;
    logic [31:0]   c_rem_q, c_rem_d;

    logic accept;
    logic hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            orphan_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            c_valid_q <= 1'b0;
            c_dvd_q   <= '0;
            c_dvs_q   <= '0;
            c_uns_q   <= 1'b0;
            c_quo_q   <= '0;
            c_rem_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            orphan_q  <= orphan_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            c_valid_q <= c_valid_d;
            c_dvd_q   <= c_dvd_d;
            c_dvs_q   <= c_dvs_d;
            c_uns_q   <= c_uns_d;
            c_quo_q   <= c_quo_d;
            c_rem_q   <= c_rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        orphan_d  = orphan_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        c_valid_d = c_valid_q;
        c_dvd_d   = c_dvd_q;
        c_dvs_d   = c_dvs_q;
        c_uns_d   = c_uns_q;
        c_quo_d   = c_quo_q;
        c_rem_d   = c_rem_q;
        div_start = 1'b0;
        req_ready = (state_q == S_IDLE) & ~flush;
        accept    = req_valid & req_ready;
        hit       = CACHE_EN & c_valid_q
                  & (req_dividend == c_dvd_q)
                  & (req_divisor == c_dvs_q)
                  & (req_op[0] == c_uns_q);

        // After a watchdog timeout the divider is still busy with the
        // abandoned op; its eventual div_fin is what frees it again.
        if (orphan_q && div_fin) begin
            orphan_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    dvd_d = req_dividend;
                    dvs_d = req_divisor;
                    if (hit) begin
                        rdata_d = req_op[1] ? c_rem_q : c_quo_q;
                        rerr_d  = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!orphan_q) begin
                    // Held here without a pulse while an abandoned op drains.
                    div_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) begin
                    state_d = div_fin ? S_IDLE : S_DRAIN;
                end else if (div_fin) begin
                    c_valid_d = 1'b1;
                    c_dvd_d   = dvd_q;
                    c_dvs_d   = dvs_q;
                    c_uns_d   = op_q[0];
                    c_quo_d   = div_quotient;
                    c_rem_d   = div_remainder;
                    rdata_d   = op_q[1] ? div_remainder : div_quotient;
                    rerr_d    = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    c_valid_d = 1'b0;
                    orphan_d  = 1'b1;
                    rdata_d   = '0;
                    rerr_d    = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_fin) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = rdata_q;
    assign resp_err     = rerr_q;
    assign busy         = (state_q != S_IDLE);
    assign div_op       = op_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule
